fifo_ctrl: RTL

Pointer and flag controller for the 16-entry, 8-bit FIFO memory array. It accepts push/pop requests and generates the gated write enable plus 5-bit write and read pointers (4 address bits, 1 wrap bit) that drive the array. It also produces full/empty, almost-full/almost-empty, fill count and sticky overflow/underflow status. It sits between the producer/consumer logic and the memory array, and together they form the complete synchronous FIFO.

---
 rtl/fifo_ctrl_pkg.sv | 16 +
 rtl/fifo_ptr.sv | 23 ++
 rtl/fifo_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the 16-entry synchronous FIFO: the controller, the
// array wrapper and the bench all size themselves from these.
//   ADDR_W_DEF   : address bits into the array
//   DEPTH_DEF    : number of array entries
//   PTR_W_DEF    : pointer width (address bits plus one wrap bit)
//   AF_LEVEL_DEF : default almost-full threshold (count >= level)
//   AE_LEVEL_DEF : default almost-empty threshold (count <= level)
package fifo_ctrl_pkg;

  localparam int ADDR_W_DEF   = 4;
  localparam int DEPTH_DEF    = 2 ** ADDR_W_DEF;
  localparam int PTR_W_DEF    = ADDR_W_DEF + 1;
  localparam int AF_LEVEL_DEF = 12;
  localparam int AE_LEVEL_DEF = 4;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer register for one side of the FIFO.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, pointer returns to zero
//   en    : advance the pointer by one at the next rising edge
//   ptr   : current pointer value, wraps modulo 2**PTR_W
module fifo_ptr #(
  parameter int PTR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for the FIFO memory array.
//   clk               : system clock
//   rst_n             : asynchronous active-low reset
//   wr / rd           : push / pop requests
//   clr_err           : synchronous clear of the sticky error flags
//   fifo_we           : gated write enable to the array
//   wptr / rptr       : write / read pointers (ADDR_W address bits + wrap bit)
//   fifo_full/empty   : count == DEPTH / count == 0
//   fifo_almost_full  : count >= AF_LEVEL
//   fifo_almost_empty : count <= AE_LEVEL
//   fifo_count        : entries held, 0..DEPTH
//   fifo_overflow     : sticky, push attempted while full
//   fifo_underflow    : sticky, pop attempted while empty
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int AF_LEVEL = AF_LEVEL_DEF,
  parameter int AE_LEVEL = AE_LEVEL_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic          rd,
  input  logic          clr_err,
  output logic          fifo_we,
  output logic [ADDR_W:0] wptr,
  output logic [ADDR_W:0] rptr,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic          fifo_almost_full,
  output logic          fifo_almost_empty,
  output logic [ADDR_W:0] fifo_count,
  output logic          fifo_overflow,
  output logic          fifo_underflow
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] AF_THR = PTR_W'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_THR = PTR_W'(AE_LEVEL);

  logic push_ok;
  logic pop_ok;

  // Requests are qualified against the registered flags only, so a push
  // into a full FIFO or a pop from an empty one never moves a pointer, and
  // there is no pass-through / fall-through when both arrive together.
  assign push_ok = wr & ~fifo_full;
  assign pop_ok  = rd & ~fifo_empty;
  assign fifo_we = push_ok;

  fifo_ptr #(.PTR_W(PTR_W)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (push_ok),
    .ptr   (wptr)
  );

  fifo_ptr #(.PTR_W(PTR_W)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pop_ok),
    .ptr   (rptr)
  );

  // Flags come from the registered pointers alone. Equal address bits with
  // differing wrap bits means the writer is a full lap ahead.
  assign fifo_empty        = (wptr == rptr);
  assign fifo_full         = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                             (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  // Modular subtraction stays correct when wptr has wrapped past rptr.
  assign fifo_count        = wptr - rptr;
  assign fifo_almost_full  = (fifo_count >= AF_THR);
  assign fifo_almost_empty = (fifo_count <= AE_THR);

  // Sticky errors: a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      fifo_overflow  <= (wr & fifo_full)  | (fifo_overflow  & ~clr_err);
      fifo_underflow <= (rd & fifo_empty) | (fifo_underflow & ~clr_err);
    end
  end

endmodule
